// File: rtl/tblink_rpc_invoke_pkg.sv
// Shared types and width helpers for the RPC invoke multiplexer.
package tblink_rpc_invoke_pkg;

   // Per-channel call state: IDLE accepts new requests, WAIT awaits a return.
   typedef enum logic [0:0] {
      CH_IDLE = 1'b0,
      CH_WAIT = 1'b1
   } ch_state_t;

   // Channel-index width; never narrower than one bit so N=1 still has a field.
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Timeout counter width, wide enough to hold the value tmo.
   function automatic int cnt_width(input int tmo);
      return (tmo < 1) ? 1 : $clog2(tmo + 1);
   endfunction

endpackage

// File: rtl/tblink_rpc_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority rotates past the last winner.
module tblink_rpc_rr_arb
   import tblink_rpc_invoke_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PW = ch_width(N);

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] win_s;
   logic          found_s;

   // Scan requesters starting at the priority pointer; first hit wins.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      gnt     = '0;
      win_s   = '0;
      found_s = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_r} + (PW+1)'(k);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end else begin
            sum = sum;
         end
         idx = sum[PW-1:0];
         if (!found_s && req[idx]) begin
            gnt[idx] = 1'b1;
            win_s    = idx;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Move priority to the channel after the winner; hold when nothing is granted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r <= '0;
      end else if (advance && found_s) begin
         ptr_r <= (win_s == PW'(N - 1)) ? '0 : win_s + PW'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/tblink_rpc_invoke_mux.sv
// Multiplexes N_CH RPC invoking channels onto one endpoint request slot and
// routes returns (or timeouts) back to the waiting channel.
module tblink_rpc_invoke_mux
   import tblink_rpc_invoke_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int MID_W = 16,
   parameter int PRM_W = 64,
   parameter int RET_W = 64,
   parameter int TMO   = 1024
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [N_CH-1:0]           ch_req_valid,
   output logic [N_CH-1:0]           ch_req_ready,
   input  logic [N_CH*MID_W-1:0]     ch_req_mid,
   input  logic [N_CH*PRM_W-1:0]     ch_req_prm,
   input  logic [N_CH-1:0]           ch_req_blk,
   output logic [N_CH-1:0]           ch_rsp_valid,
   output logic [N_CH*RET_W-1:0]     ch_rsp_ret,
   output logic [N_CH-1:0]           ch_rsp_err,
   output logic [N_CH-1:0]           ch_busy,
   output logic                      ep_req_valid,
   input  logic                      ep_req_ready,
   output logic [ch_width(N_CH)-1:0] ep_req_ch,
   output logic [MID_W-1:0]          ep_req_mid,
   output logic [PRM_W-1:0]          ep_req_prm,
   output logic                      ep_req_blk,
   input  logic                      ep_rsp_valid,
   input  logic [ch_width(N_CH)-1:0] ep_rsp_ch,
   input  logic [RET_W-1:0]          ep_rsp_ret,
   output logic                      stray_rsp
);

   localparam int CH_W  = ch_width(N_CH);
   localparam int CNT_W = cnt_width(TMO);
   localparam logic [CNT_W-1:0] TMO_LAST = (TMO == 0) ? '0 : CNT_W'(TMO - 1);

   ch_state_t        state_r     [N_CH];
   ch_state_t        state_nxt_s [N_CH];
   logic [CNT_W-1:0] cnt_r       [N_CH];
   logic [CNT_W-1:0] cnt_nxt_s   [N_CH];

   logic [N_CH-1:0]  eligible_s;
   logic [N_CH-1:0]  gnt_s;
   logic             slot_free_s;
   logic [N_CH-1:0]  rsp_hit_s;
   logic [N_CH-1:0]  done_ok_s;
   logic [N_CH-1:0]  done_tmo_s;
   logic [CH_W-1:0]  win_ch_s;
   logic [MID_W-1:0] win_mid_s;
   logic [PRM_W-1:0] win_prm_s;
   logic             win_blk_s;

   // Only idle channels compete; a return is a hit only for a waiting channel.
   always_comb begin
      eligible_s = '0;
      rsp_hit_s  = '0;
      for (int i = 0; i < N_CH; i++) begin
         eligible_s[i] = ch_req_valid[i] && (state_r[i] == CH_IDLE);
         rsp_hit_s[i]  = ep_rsp_valid && (ep_rsp_ch == CH_W'(i)) &&
                         (state_r[i] == CH_WAIT);
      end
   end

   tblink_rpc_rr_arb #(
      .N (N_CH)
   ) u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (eligible_s),
      .advance (slot_free_s),
      .gnt     (gnt_s)
   );

   // Grant is exposed only when the endpoint slot can take a new request.
   always_comb begin
      slot_free_s  = reset_n && (!ep_req_valid || ep_req_ready);
      ch_req_ready = slot_free_s ? gnt_s : '0;
   end

   // Select the winning channel's request fields.
   always_comb begin
      win_ch_s  = '0;
      win_mid_s = '0;
      win_prm_s = '0;
      win_blk_s = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_s[i]) begin
            win_ch_s  = CH_W'(i);
            win_mid_s = ch_req_mid[i*MID_W +: MID_W];
            win_prm_s = ch_req_prm[i*PRM_W +: PRM_W];
            win_blk_s = ch_req_blk[i];
         end else begin
            win_ch_s  = win_ch_s;
         end
      end
   end

   // Endpoint request slot: load on acceptance, clear when consumed, else hold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ep_req_valid <= 1'b0;
         ep_req_ch    <= '0;
         ep_req_mid   <= '0;
         ep_req_prm   <= '0;
         ep_req_blk   <= 1'b0;
      end else if (|ch_req_ready) begin
         ep_req_valid <= 1'b1;
         ep_req_ch    <= win_ch_s;
         ep_req_mid   <= win_mid_s;
         ep_req_prm   <= win_prm_s;
         ep_req_blk   <= win_blk_s;
      end else if (ep_req_ready) begin
         ep_req_valid <= 1'b0;
      end else begin
         ep_req_valid <= ep_req_valid;
      end
   end

   // Channel state and timeout counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_CH; i++) begin
            state_r[i] <= CH_IDLE;
            cnt_r[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_r[i] <= state_nxt_s[i];
            cnt_r[i]   <= cnt_nxt_s[i];
         end
      end
   end

   // Channel next-state: blocking acceptance enters WAIT; a return beats expiry.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         state_nxt_s[i] = state_r[i];
         cnt_nxt_s[i]   = cnt_r[i];
         done_ok_s[i]   = 1'b0;
         done_tmo_s[i]  = 1'b0;
         case (state_r[i])
            CH_IDLE: begin
               if (ch_req_ready[i] && ch_req_blk[i]) begin
                  state_nxt_s[i] = CH_WAIT;
                  cnt_nxt_s[i]   = '0;
               end else begin
                  state_nxt_s[i] = CH_IDLE;
               end
            end
            CH_WAIT: begin
               if (rsp_hit_s[i]) begin
                  state_nxt_s[i] = CH_IDLE;
                  done_ok_s[i]   = 1'b1;
               end else if ((TMO != 0) && (cnt_r[i] == TMO_LAST)) begin
                  state_nxt_s[i] = CH_IDLE;
                  done_tmo_s[i]  = 1'b1;
               end else begin
                  cnt_nxt_s[i]   = cnt_r[i] + CNT_W'(1);
               end
            end
            default: begin
               state_nxt_s[i] = CH_IDLE;
               cnt_nxt_s[i]   = '0;
            end
         endcase
      end
   end

   // Busy is a direct decode of the WAIT state.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ch_busy[i] = (state_r[i] == CH_WAIT);
      end
   end

   // Completion pulse; the return value holds between pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ch_rsp_valid <= '0;
         ch_rsp_ret   <= '0;
         ch_rsp_err   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            ch_rsp_valid[i] <= done_ok_s[i] || done_tmo_s[i];
            ch_rsp_err[i]   <= done_tmo_s[i];
            if (done_ok_s[i]) begin
               ch_rsp_ret[i*RET_W +: RET_W] <= ep_rsp_ret;
            end else if (done_tmo_s[i]) begin
               ch_rsp_ret[i*RET_W +: RET_W] <= '0;
            end else begin
               ch_rsp_ret[i*RET_W +: RET_W] <= ch_rsp_ret[i*RET_W +: RET_W];
            end
         end
      end
   end

   // Sticky flag for returns nobody was waiting for.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stray_rsp <= 1'b0;
      end else if (ep_rsp_valid && !(|rsp_hit_s)) begin
         stray_rsp <= 1'b1;
      end else begin
         stray_rsp <= stray_rsp;
      end
   end

endmodule

// File: tb/tb_tblink_rpc_invoke_mux.sv
// Self-checking bench: directed scenarios plus random traffic against a
// deadline-based reference model of the invoke multiplexer.
module tb_tblink_rpc_invoke_mux;

   localparam int N   = 4;
   localparam int MW  = 16;
   localparam int PW  = 64;
   localparam int RW  = 64;
   localparam int TMO = 8;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    ch_req_valid = '0;
   logic [N-1:0]    ch_req_ready;
   logic [N*MW-1:0] ch_req_mid = '0;
   logic [N*PW-1:0] ch_req_prm = '0;
   logic [N-1:0]    ch_req_blk = '0;
   logic [N-1:0]    ch_rsp_valid;
   logic [N*RW-1:0] ch_rsp_ret;
   logic [N-1:0]    ch_rsp_err;
   logic [N-1:0]    ch_busy;
   logic            ep_req_valid;
   logic            ep_req_ready = 1'b0;
   logic [1:0]      ep_req_ch;
   logic [MW-1:0]   ep_req_mid;
   logic [PW-1:0]   ep_req_prm;
   logic            ep_req_blk;
   logic            ep_rsp_valid = 1'b0;
   logic [1:0]      ep_rsp_ch = '0;
   logic [RW-1:0]   ep_rsp_ret = '0;
   logic            stray_rsp;

   tblink_rpc_invoke_mux #(
      .N_CH (N), .MID_W (MW), .PRM_W (PW), .RET_W (RW), .TMO (TMO)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .ch_req_valid (ch_req_valid),
      .ch_req_ready (ch_req_ready),
      .ch_req_mid   (ch_req_mid),
      .ch_req_prm   (ch_req_prm),
      .ch_req_blk   (ch_req_blk),
      .ch_rsp_valid (ch_rsp_valid),
      .ch_rsp_ret   (ch_rsp_ret),
      .ch_rsp_err   (ch_rsp_err),
      .ch_busy      (ch_busy),
      .ep_req_valid (ep_req_valid),
      .ep_req_ready (ep_req_ready),
      .ep_req_ch    (ep_req_ch),
      .ep_req_mid   (ep_req_mid),
      .ep_req_prm   (ep_req_prm),
      .ep_req_blk   (ep_req_blk),
      .ep_rsp_valid (ep_rsp_valid),
      .ep_rsp_ch    (ep_rsp_ch),
      .ep_rsp_ret   (ep_rsp_ret),
      .stray_rsp    (stray_rsp)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit auto_drop = 1'b0;

   // Reference model state: pending call deadlines instead of counters.
   bit          m_ep_valid;
   logic [1:0]  m_ep_ch;
   logic [15:0] m_ep_mid;
   logic [63:0] m_ep_prm;
   logic        m_ep_blk;
   int          m_ptr;
   logic [3:0]  m_busy;
   logic [3:0]  m_rsp_valid;
   logic [3:0]  m_err;
   logic [63:0] m_ret [N];
   int          m_deadline [N];
   logic        m_stray;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_ep_valid  = 1'b0;
      m_ep_ch     = '0;
      m_ep_mid    = '0;
      m_ep_prm    = '0;
      m_ep_blk    = 1'b0;
      m_ptr       = 0;
      m_busy      = '0;
      m_rsp_valid = '0;
      m_err       = '0;
      m_stray     = 1'b0;
      for (int c = 0; c < N; c++) begin
         m_ret[c]      = '0;
         m_deadline[c] = 0;
      end
   endfunction

   // One clock cycle: check outputs, advance the model, cross one posedge.
   task automatic step();
      int         win;
      bit         free;
      logic [3:0] exp_rdy;
      #1;
      check_eq("ep_valid", ep_req_valid, m_ep_valid);
      check_eq("ep_ch", ep_req_ch, m_ep_ch);
      check_eq("ep_mid", ep_req_mid, m_ep_mid);
      check_eq("ep_prm", ep_req_prm, m_ep_prm);
      check_eq("ep_blk", ep_req_blk, m_ep_blk);
      check_eq("rsp_valid", ch_rsp_valid, m_rsp_valid);
      check_eq("rsp_err", ch_rsp_err & ch_rsp_valid, m_err & m_rsp_valid);
      check_eq("busy", ch_busy, m_busy);
      check_eq("stray", stray_rsp, m_stray);
      for (int c = 0; c < N; c++) begin
         check_eq("rsp_ret", ch_rsp_ret[c*RW +: RW], m_ret[c]);
      end
      free = !m_ep_valid || ep_req_ready;
      win  = -1;
      if (free) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (win < 0 && ch_req_valid[j] && !m_busy[j]) win = j;
         end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      check_eq("req_ready", ch_req_ready, exp_rdy);
      m_rsp_valid = '0;
      if (ep_rsp_valid) begin
         if (m_busy[ep_rsp_ch]) begin
            m_busy[ep_rsp_ch]      = 1'b0;
            m_rsp_valid[ep_rsp_ch] = 1'b1;
            m_err[ep_rsp_ch]       = 1'b0;
            m_ret[ep_rsp_ch]       = ep_rsp_ret;
         end else begin
            m_stray = 1'b1;
         end
      end
      for (int c = 0; c < N; c++) begin
         if (m_busy[c] && cyc == m_deadline[c]) begin
            m_busy[c]      = 1'b0;
            m_rsp_valid[c] = 1'b1;
            m_err[c]       = 1'b1;
            m_ret[c]       = '0;
         end
      end
      if (win >= 0) begin
         if (ch_req_blk[win]) begin
            m_busy[win]     = 1'b1;
            m_deadline[win] = cyc + TMO;
         end
         m_ep_valid = 1'b1;
         m_ep_ch    = 2'(win);
         m_ep_mid   = ch_req_mid[win*MW +: MW];
         m_ep_prm   = ch_req_prm[win*PW +: PW];
         m_ep_blk   = ch_req_blk[win];
         m_ptr      = (win + 1) % N;
      end else if (ep_req_ready) begin
         m_ep_valid = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (auto_drop && win >= 0) ch_req_valid[win] = 1'b0;
   endtask

   // Pulse reset while inputs are active; every output must drop at once.
   task automatic do_reset();
      #2;
      ch_req_valid = 4'hF;
      ep_req_ready = 1'b1;
      reset_n      = 1'b0;
      #1;
      check_eq("rst_ep_valid", ep_req_valid, 64'd0);
      check_eq("rst_ep_ch", ep_req_ch, 64'd0);
      check_eq("rst_ep_mid", ep_req_mid, 64'd0);
      check_eq("rst_ep_prm", ep_req_prm, 64'd0);
      check_eq("rst_ep_blk", ep_req_blk, 64'd0);
      check_eq("rst_req_ready", ch_req_ready, 64'd0);
      check_eq("rst_rsp_valid", ch_rsp_valid, 64'd0);
      check_eq("rst_rsp_err", ch_rsp_err, 64'd0);
      check_eq("rst_busy", ch_busy, 64'd0);
      check_eq("rst_stray", stray_rsp, 64'd0);
      for (int c = 0; c < N; c++) begin
         check_eq("rst_rsp_ret", ch_rsp_ret[c*RW +: RW], 64'd0);
      end
      model_reset();
      repeat (2) begin
         @(posedge clock);
         @(negedge clock);
         cyc++;
      end
      ch_req_valid = '0;
      ch_req_blk   = '0;
      ep_req_ready = 1'b1;
      ep_rsp_valid = 1'b0;
      reset_n      = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      @(negedge clock);

      // Four simultaneous non-blocking requests drain in channel order.
      do_reset();
      auto_drop  = 1'b1;
      ch_req_blk = '0;
      for (int c = 0; c < N; c++) ch_req_mid[c*MW +: MW] = 16'(16'h100 + c);
      ch_req_valid = 4'hF;
      for (int k = 0; k < N; k++) begin
         step();
         check_eq("seq_valid", ep_req_valid, 64'd1);
         check_eq("seq_ch", ep_req_ch, 64'(k));
      end
      step();
      check_eq("seq_idle", ep_req_valid, 64'd0);
      check_eq("seq_no_rsp", ch_rsp_valid, 64'd0);

      // Blocking call on ch2 answered after five cycles.
      do_reset();
      ch_req_mid[2*MW +: MW] = 16'h0012;
      ch_req_blk[2]   = 1'b1;
      ch_req_valid[2] = 1'b1;
      step();
      check_eq("b24_mid", ep_req_mid, 64'h12);
      check_eq("b24_ch", ep_req_ch, 64'd2);
      check_eq("b24_busy", ch_busy, 64'h4);
      repeat (4) step();
      ep_rsp_valid = 1'b1;
      ep_rsp_ch    = 2'd2;
      ep_rsp_ret   = 64'hDEAD;
      step();
      ep_rsp_valid = 1'b0;
      check_eq("b24_pulse", ch_rsp_valid, 64'h4);
      check_eq("b24_ret", ch_rsp_ret[2*RW +: RW], 64'hDEAD);
      check_eq("b24_err", ch_rsp_err[2], 64'd0);
      check_eq("b24_idle", ch_busy, 64'd0);
      step();
      check_eq("b24_hold", ch_rsp_ret[2*RW +: RW], 64'hDEAD);

      // Timeout on ch1, then a late return is stray.
      do_reset();
      ch_req_blk[1]   = 1'b1;
      ch_req_valid[1] = 1'b1;
      step();
      repeat (7) step();
      check_eq("b25_early", ch_rsp_valid[1], 64'd0);
      step();
      check_eq("b25_pulse", ch_rsp_valid[1], 64'd1);
      check_eq("b25_err", ch_rsp_err[1], 64'd1);
      check_eq("b25_ret", ch_rsp_ret[1*RW +: RW], 64'd0);
      ep_rsp_valid = 1'b1;
      ep_rsp_ch    = 2'd1;
      ep_rsp_ret   = 64'h55;
      step();
      ep_rsp_valid = 1'b0;
      check_eq("b25_stray", stray_rsp, 64'd1);

      // Return on the expiry cycle wins over the timeout.
      do_reset();
      ch_req_blk[3]   = 1'b1;
      ch_req_valid[3] = 1'b1;
      step();
      repeat (7) step();
      ep_rsp_valid = 1'b1;
      ep_rsp_ch    = 2'd3;
      ep_rsp_ret   = 64'h0123_4567_89AB_CDEF;
      step();
      ep_rsp_valid = 1'b0;
      check_eq("b26_pulse", ch_rsp_valid, 64'h8);
      check_eq("b26_err", ch_rsp_err[3], 64'd0);
      check_eq("b26_ret", ch_rsp_ret[3*RW +: RW], 64'h0123_4567_89AB_CDEF);
      check_eq("b26_stray", stray_rsp, 64'd0);

      // Endpoint back-pressure holds the slot stable.
      do_reset();
      ch_req_blk             = '0;
      ch_req_mid[0*MW +: MW] = 16'hA5A5;
      ch_req_prm[0*PW +: PW] = 64'hFEED_0000_BEEF;
      ch_req_valid[0]        = 1'b1;
      step();
      ep_req_ready    = 1'b0;
      ch_req_valid[1] = 1'b1;
      ch_req_valid[2] = 1'b1;
      repeat (3) begin
         step();
         check_eq("b27_valid", ep_req_valid, 64'd1);
         check_eq("b27_ch", ep_req_ch, 64'd0);
         check_eq("b27_mid", ep_req_mid, 64'hA5A5);
         check_eq("b27_prm", ep_req_prm, 64'hFEED_0000_BEEF);
         check_eq("b27_ready", ch_req_ready, 64'd0);
      end
      ep_req_ready = 1'b1;
      step();
      check_eq("b27_next", ep_req_ch, 64'd1);
      step();

      // Reset while ch1 waits; the following return is stray.
      do_reset();
      ch_req_blk[1]   = 1'b1;
      ch_req_valid[1] = 1'b1;
      step();
      repeat (2) step();
      check_eq("b28_busy", ch_busy, 64'h2);
      do_reset();
      ep_rsp_valid = 1'b1;
      ep_rsp_ch    = 2'd1;
      ep_rsp_ret   = 64'h77;
      step();
      ep_rsp_valid = 1'b0;
      check_eq("b28_stray", stray_rsp, 64'd1);
      check_eq("b28_no_rsp", ch_rsp_valid, 64'd0);

      // Random traffic checked cycle by cycle against the model.
      do_reset();
      auto_drop = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         ch_req_valid = 4'($urandom);
         ch_req_blk   = 4'($urandom);
         for (int c = 0; c < N; c++) begin
            ch_req_mid[c*MW +: MW] = 16'($urandom);
            ch_req_prm[c*PW +: PW] = {$urandom, $urandom};
         end
         ep_req_ready = ($urandom_range(3) != 0);
         ep_rsp_valid = ($urandom_range(2) == 0);
         ep_rsp_ch    = 2'($urandom);
         ep_rsp_ret   = {$urandom, $urandom};
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
